// File: rtl/oam_dma_if.sv
// CPU-side bus bundle for the sprite DMA controller: CPU request/data in, DMA bus master out.
// master = CPU/bus side, slave = oam_dma_ctrl.
interface oam_dma_if;
   logic [15:0] cpu_addr;
   logic        cpu_wr_n;
   logic [7:0]  cpu_dout;
   logic        odd_or_even;
   logic [7:0]  bus_rdata;
   logic        cpu_rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_wr_n;
   logic [7:0]  dma_dout;
   logic        dma_done;

   modport master (
      output cpu_addr, cpu_wr_n, cpu_dout, odd_or_even, bus_rdata,
      input  cpu_rdy, dma_active, dma_addr, dma_wr_n, dma_dout, dma_done
   );

   modport slave (
      input  cpu_addr, cpu_wr_n, cpu_dout, odd_or_even, bus_rdata,
      output cpu_rdy, dma_active, dma_addr, dma_wr_n, dma_dout, dma_done
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies 256 bytes from
// {page,$00..$FF} to OAM_DATA_ADDR as read/write pairs. All outputs are registered.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter bit          ALIGN_EN      = 1'b1
) (
   input logic       cpu_clk,
   input logic       reset,
   oam_dma_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  page, page_nxt;
   logic [7:0]  idx, idx_nxt;
   logic        trigger;

   logic        cpu_rdy_nxt;
   logic        dma_active_nxt;
   logic [15:0] dma_addr_nxt;
   logic        dma_wr_n_nxt;
   logic [7:0]  dma_dout_nxt;
   logic        dma_done_nxt;

   assign trigger = (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_wr_n && bus.cpu_rdy;

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state <= S_IDLE;
         page  <= 8'h00;
         idx   <= 8'h00;
      end else begin
         state <= state_nxt;
         page  <= page_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      page_nxt  = page;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               page_nxt  = bus.cpu_dout;
               idx_nxt   = 8'h00;
               state_nxt = S_HALT;
            end
         end
         // Rdy does not stop CPU writes, so wait until the write burst drains.
         S_HALT: begin
            if (bus.cpu_wr_n)
               state_nxt = (ALIGN_EN && bus.odd_or_even) ? S_ALIGN : S_READ;
         end
         S_ALIGN: state_nxt = S_READ;
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: begin
            if (idx == 8'hFF) begin
               state_nxt = S_IDLE;
            end else begin
               idx_nxt   = idx + 8'd1;
               state_nxt = S_READ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered value matches the state it belongs to.
   always_comb begin
      cpu_rdy_nxt    = (state_nxt == S_IDLE);
      dma_active_nxt = (state_nxt == S_ALIGN) || (state_nxt == S_READ) || (state_nxt == S_WRITE);
      dma_wr_n_nxt   = (state_nxt != S_WRITE);
      dma_done_nxt   = (state == S_WRITE) && (idx == 8'hFF);
      dma_dout_nxt   = bus.dma_dout;
      dma_addr_nxt   = bus.dma_addr;
      if (state == S_READ)
         dma_dout_nxt = bus.bus_rdata;
      case (state_nxt)
         S_ALIGN, S_WRITE: dma_addr_nxt = OAM_DATA_ADDR;
         S_READ:           dma_addr_nxt = {page_nxt, idx_nxt};
         default:          dma_addr_nxt = bus.dma_addr;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         bus.cpu_rdy    <= 1'b1;
         bus.dma_active <= 1'b0;
         bus.dma_addr   <= 16'h0000;
         bus.dma_wr_n   <= 1'b1;
         bus.dma_dout   <= 8'h00;
         bus.dma_done   <= 1'b0;
      end else begin
         bus.cpu_rdy    <= cpu_rdy_nxt;
         bus.dma_active <= dma_active_nxt;
         bus.dma_addr   <= dma_addr_nxt;
         bus.dma_wr_n   <= dma_wr_n_nxt;
         bus.dma_dout   <= dma_dout_nxt;
         bus.dma_done   <= dma_done_nxt;
      end
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: directed triggers push expected bus cycles and stall lengths;
// a negedge monitor pops and compares them as the DMA drives the bus.
module tb_oam_dma_ctrl;

   logic cpu_clk = 1'b0;
   logic reset   = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   oam_dma_if bif ();

   oam_dma_ctrl #(
      .DMA_REG_ADDR  (16'h4014),
      .OAM_DATA_ADDR (16'h2004),
      .ALIGN_EN      (1'b1)
   ) dut (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .bus     (bif.slave)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      logic        wr_n;
      logic [15:0] addr;
      logic [7:0]  data;
      bit          chk_data;
   } cyc_t;

   cyc_t exp_q[$];
   int   exp_stall[$];

   // Source RAM contents: page $02 holds i^$A5, other pages i^(page^$5A).
   function automatic logic [7:0] key(input logic [7:0] p);
      return (p == 8'h02) ? 8'hA5 : (p ^ 8'h5A);
   endfunction

   function automatic logic [7:0] rd_model(input logic [15:0] a);
      logic [7:0] lo, hi;
      lo = a[7:0];
      hi = a[15:8];
      if (a == 16'h2004) return 8'hEE;
      return lo ^ key(hi);
   endfunction

   always_comb begin
      bif.bus_rdata = 8'h00;
      if (bif.dma_active && bif.dma_wr_n)
         bif.bus_rdata = rd_model(bif.dma_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_xfer(input logic [7:0] page, input bit align, input int extra_halt);
      cyc_t c;
      exp_stall.push_back(1 + extra_halt + (align ? 1 : 0) + 512);
      if (align) begin
         c.wr_n = 1'b1; c.addr = 16'h2004; c.data = 8'h00; c.chk_data = 1'b0;
         exp_q.push_back(c);
      end
      for (int i = 0; i < 256; i++) begin
         c.wr_n = 1'b1; c.addr = {page, i[7:0]}; c.data = 8'h00; c.chk_data = 1'b0;
         exp_q.push_back(c);
         c.wr_n = 1'b0; c.addr = 16'h2004; c.data = i[7:0] ^ key(page); c.chk_data = 1'b1;
         exp_q.push_back(c);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge cpu_clk);
   endtask

   // Entered and left at a negedge; extra_wr emulates pending CPU write cycles.
   task automatic trig(input logic [7:0] page, input int extra_wr);
      bif.cpu_addr = 16'h4014; bif.cpu_wr_n = 1'b0; bif.cpu_dout = page;
      @(negedge cpu_clk);
      for (int k = 0; k < extra_wr; k++) begin
         bif.cpu_addr = 16'h01FF - 16'(k); bif.cpu_wr_n = 1'b0; bif.cpu_dout = 8'h3C;
         @(negedge cpu_clk);
      end
      bif.cpu_addr = 16'h8000; bif.cpu_wr_n = 1'b1; bif.cpu_dout = 8'h00;
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge cpu_clk);
         if (bif.dma_done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   // Monitor: compares every DMA bus cycle and every CPU stall window against the queues.
   initial begin
      int   stall_cnt;
      cyc_t e;
      stall_cnt = 0;
      forever begin
         @(negedge cpu_clk);
         if (!mon_en) begin
            stall_cnt = 0;
         end else begin
            if (bif.dma_active === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL bus_unexpected: got addr %h wr_n %b expected no DMA cycle",
                           bif.dma_addr, bif.dma_wr_n);
               end else begin
                  e = exp_q.pop_front();
                  check("bus_cycle",
                        {7'd0, bif.dma_wr_n, bif.dma_addr, (e.chk_data ? bif.dma_dout : 8'h00)},
                        {7'd0, e.wr_n, e.addr, e.data});
               end
            end
            if (bif.cpu_rdy !== 1'b1) begin
               stall_cnt++;
            end else if (stall_cnt != 0) begin
               if (exp_stall.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL stall_unexpected: got stall of %0d cycles expected none", stall_cnt);
               end else begin
                  check("stall_len", 32'(stall_cnt), 32'(exp_stall.pop_front()));
               end
               check("done_with_rdy", 32'(bif.dma_done), 32'd1);
               stall_cnt = 0;
            end else if (bif.dma_done !== 1'b0) begin
               check("done_spurious", 32'(bif.dma_done), 32'd0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bif.cpu_addr = 16'h8000; bif.cpu_wr_n = 1'b1; bif.cpu_dout = 8'h00;
      bif.odd_or_even = 1'b0;
      reset = 1'b1;
      idle(3);
      check("rst_cpu_rdy",    32'(bif.cpu_rdy),    32'd1);
      check("rst_dma_active", 32'(bif.dma_active), 32'd0);
      check("rst_dma_addr",   32'(bif.dma_addr),   32'h0000);
      check("rst_dma_wr_n",   32'(bif.dma_wr_n),   32'd1);
      check("rst_dma_dout",   32'(bif.dma_dout),   32'h00);
      check("rst_dma_done",   32'(bif.dma_done),   32'd0);
      reset = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Ignored accesses: read of $4014, write to $4015.
      bif.cpu_addr = 16'h4014; bif.cpu_wr_n = 1'b1; bif.cpu_dout = 8'h09;
      @(negedge cpu_clk);
      bif.cpu_addr = 16'h4015; bif.cpu_wr_n = 1'b0; bif.cpu_dout = 8'h09;
      @(negedge cpu_clk);
      bif.cpu_addr = 16'h8000; bif.cpu_wr_n = 1'b1;
      idle(3);
      check("ignored_rdy", 32'(bif.cpu_rdy), 32'd1);

      // Basic copy, even parity.
      push_xfer(8'h02, 1'b0, 0);
      trig(8'h02, 0);
      wait_done(1200);
      idle(3);

      // Odd parity at HALT exit adds a dummy read.
      bif.odd_or_even = 1'b1;
      push_xfer(8'h02, 1'b1, 0);
      trig(8'h02, 0);
      wait_done(1200);
      bif.odd_or_even = 1'b0;
      idle(3);

      // Two pending CPU writes stretch HALT.
      push_xfer(8'h05, 1'b0, 2);
      trig(8'h05, 2);
      wait_done(1200);
      idle(3);

      // Write to $4014 mid-transfer must be ignored.
      push_xfer(8'h06, 1'b0, 0);
      trig(8'h06, 0);
      idle(20);
      bif.cpu_addr = 16'h4014; bif.cpu_wr_n = 1'b0; bif.cpu_dout = 8'h77;
      @(negedge cpu_clk);
      bif.cpu_addr = 16'h8000; bif.cpu_wr_n = 1'b1; bif.cpu_dout = 8'h00;
      wait_done(1200);
      idle(3);

      // Back-to-back: re-trigger in the dma_done cycle.
      push_xfer(8'h02, 1'b0, 0);
      trig(8'h02, 0);
      wait_done(1200);
      push_xfer(8'h03, 1'b0, 0);
      trig(8'h03, 0);
      wait_done(1200);
      idle(3);
      check("queue_bus_empty",   32'(exp_q.size()),     32'd0);
      check("queue_stall_empty", 32'(exp_stall.size()), 32'd0);

      // Reset in the middle of a transfer at idx $40.
      mon_en = 1'b0;
      trig(8'h07, 0);
      begin
         bit hit;
         hit = 1'b0;
         for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge cpu_clk);
            if (bif.dma_active && bif.dma_wr_n && bif.dma_addr == 16'h0740) hit = 1'b1;
         end
         check("mid_idx40_reached", 32'(hit), 32'd1);
      end
      reset = 1'b1;
      @(negedge cpu_clk);
      check("mid_rst_cpu_rdy",    32'(bif.cpu_rdy),    32'd1);
      check("mid_rst_dma_active", 32'(bif.dma_active), 32'd0);
      check("mid_rst_dma_addr",   32'(bif.dma_addr),   32'h0000);
      check("mid_rst_dma_wr_n",   32'(bif.dma_wr_n),   32'd1);
      reset = 1'b0;
      idle(4);
      check("post_rst_idle_rdy",    32'(bif.cpu_rdy),    32'd1);
      check("post_rst_idle_active", 32'(bif.dma_active), 32'd0);
      mon_en = 1'b1;

      // Fresh transfer after the aborted one starts from idx 0.
      push_xfer(8'h01, 1'b0, 0);
      trig(8'h01, 0);
      wait_done(1200);
      idle(3);
      check("final_bus_empty",   32'(exp_q.size()),     32'd0);
      check("final_stall_empty", 32'(exp_stall.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA controller for the CPU bus.
- A CPU write to $4014 latches a source page. The block then stalls the T65 through Rdy and takes the bus.
- It copies 256 bytes from {page,$00..$FF} to the PPU OAM data port $2004 as alternating read/write cycles, then returns the bus to the CPU.
- It sits between the T65 and the databus/PPU address mux; dma_active selects the bus master.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address driven on every DMA write cycle.
- ALIGN_EN, 1, when 1 an extra alignment cycle is inserted if the halt ends on an odd CPU cycle.

Ports:
- cpu_clk  in  1  CPU clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address output (bus_addr[15:0]).
- cpu_wr_n  in  1  CPU R_W_n (1 = read, 0 = write).
- cpu_dout  in  8  CPU write data.
- odd_or_even  in  1  CPU cycle parity, 1 = odd cycle.
- bus_rdata  in  8  databus read data, valid at the end of a read cycle.
- cpu_rdy  out  1  to T65 Rdy; 0 stalls the CPU.
- dma_active  out  1  1 = DMA owns the bus; selects dma_addr/dma_wr_n/dma_dout in the bus mux.
- dma_addr  out  16  DMA bus address.
- dma_wr_n  out  1  DMA R/W (1 = read).
- dma_dout  out  8  DMA write data.
- dma_done  out  1  one-cycle pulse after the final OAM write.

Behaviour:
- All outputs are registered.
- Reset values: cpu_rdy=1, dma_active=0, dma_addr=16'h0000, dma_wr_n=1, dma_dout=8'h00, dma_done=0, state=IDLE, page=0, idx=0.
- Reset asserted in any state returns to IDLE on the next edge with reset values. No partial-transfer resume.
- Trigger: in IDLE, on an edge where cpu_addr==DMA_REG_ADDR && cpu_wr_n==0 && cpu_rdy==1:
  - page <= cpu_dout, idx <= 0, go to HALT.
  - cpu_rdy=0 from the next cycle.
- IDLE:
  - cpu_rdy=1, dma_active=0.
  - Writes to other addresses and reads of $4014 are ignored.
- HALT:
  - cpu_rdy=0, dma_active=0 (T65 continues pending write cycles, since Rdy does not stop writes).
  - Stays in HALT while cpu_wr_n==0.
  - When cpu_wr_n==1: go to ALIGN if ALIGN_EN && odd_or_even==1, else go to READ.
- ALIGN:
  - One cycle, dma_active=1, dma_wr_n=1, dma_addr=OAM_DATA_ADDR (dummy read).
  - Then go to READ.
- READ:
  - dma_active=1, dma_addr={page,idx}, dma_wr_n=1.
  - At end of cycle, data <= bus_rdata.
  - Then go to WRITE.
- WRITE:
  - dma_active=1, dma_addr=OAM_DATA_ADDR, dma_wr_n=0, dma_dout=data.
  - If idx==8'hFF: go to IDLE, assert dma_done for the next cycle, cpu_rdy=1 in that cycle.
  - Else: idx <= idx+1, go to READ.
- idx is 8-bit. Page crossing never occurs and the source high byte is constant for the transfer.
- Transfer length with no pending CPU writes: 1 HALT + 512 (+1 ALIGN) = 513 or 514 stalled cycles.
- Each pending CPU write cycle extends HALT by one cycle.
- Any CPU write to DMA_REG_ADDR while state≠IDLE is ignored. The CPU is stalled, and DMA-mastered writes never target $4014.
- Source page $20–$3F or $40: copied verbatim. Side effects belong to the addressed device, not this block.
- dma_done and the cpu_rdy rise occur in the same cycle.

Test Plan:
- Reset check: hold reset 3 cycles -> all outputs at reset values; assert reset mid-transfer at idx=8'h40 -> next cycle cpu_rdy=1, dma_active=0, state IDLE.
- Basic copy: write $02 to $4014 on an even-halt path, source RAM $0200+i = i^8'hA5 -> 256 writes to $2004 with data i^8'hA5 in order; cpu_rdy low exactly 513 cycles; dma_done single pulse.
- Odd alignment: same trigger with odd_or_even=1 at HALT exit -> one extra dummy read at $2004, cpu_rdy low 514 cycles, data sequence unchanged.
- Pending writes: hold cpu_wr_n=0 for 2 cycles after trigger (JSR push emulation) -> HALT lasts 3 cycles, first read {page,00} follows, total stall 515 (even parity).
- Ignored triggers: read of $4014, write to $4015, write to $4014 during an active transfer -> no state change, page unchanged, transfer count still 256.
- Back-to-back: re-trigger with page $03 on the first cycle after dma_done -> new transfer starts, first DMA read address $0300.
